// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer and the ALU decoder.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [4:0] OP_MFLO  = 5'd11;
    localparam logic [4:0] OP_MFHI  = 5'd12;
    localparam logic [4:0] OP_DIVU  = 5'd13;
    localparam logic [4:0] OP_MULTU = 5'd14;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_e;

    function automatic logic is_muldiv_op(input logic [4:0] op);
        return (op == OP_MFLO) || (op == OP_MFHI) || (op == OP_DIVU) || (op == OP_MULTU);
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the shared datapath: shift-add multiply (mode 0) or restoring divide (mode 1).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_i,
    input  logic [XLEN-1:0] hi_i,
    input  logic [XLEN-1:0] lo_i,
    input  logic [XLEN-1:0] opd_i,
    output logic [XLEN-1:0] hi_o,
    output logic [XLEN-1:0] lo_o
);

    logic [XLEN:0]   sum;
    logic [XLEN:0]   diff;
    logic [XLEN-1:0] restore;

    always_comb begin
        sum     = {1'b0, hi_i} + (lo_i[0] ? {1'b0, opd_i} : '0);
        // A borrow out of the XLEN+1 bit subtraction means the divisor did not fit.
        diff    = {hi_i, lo_i[XLEN-1]} - {1'b0, opd_i};
        restore = {hi_i[XLEN-2:0], lo_i[XLEN-1]};
        if (!mode_i) begin
            hi_o = sum[XLEN:1];
            lo_o = {sum[0], lo_i[XLEN-1:1]};
        end else if (!diff[XLEN]) begin
            hi_o = diff[XLEN-1:0];
            lo_o = {lo_i[XLEN-2:0], 1'b1};
        end else begin
            hi_o = restore;
            lo_o = {lo_i[XLEN-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULTU/DIVU controller owning the HI/LO pair.
// Optional MULDIV_EARLY_OUT_EN: zero-operand and leading-zero early termination for MULTU.
module muldiv_sequencer #(
    parameter int XLEN  = muldiv_pkg::XLEN,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic            stall,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);

    import muldiv_pkg::*;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]   wrk_q, wrk_d;
    logic [XLEN-1:0]   opd_q, opd_d;
    logic [XLEN-1:0]   hi_q, hi_d;
    logic [XLEN-1:0]   lo_q, lo_d;

    logic [XLEN-1:0]   step_hi;
    logic [XLEN-1:0]   step_lo;
    logic              mul_last;
    logic              mul_zero;
    logic [2*XLEN-1:0] prod;

    muldiv_step #(.XLEN(XLEN)) u_step (
        .mode_i (state_q == DIV),
        .hi_i   (acc_q),
        .lo_i   (wrk_q),
        .opd_i  (opd_q),
        .hi_o   (step_hi),
        .lo_o   (step_lo)
    );

`ifdef MULDIV_EARLY_OUT_EN
    logic [CNT_W-1:0] steps;
    assign steps    = cnt_q + CNT_W'(1);
    // Low XLEN-steps bits of the shifted word are the multiplier bits not yet consumed.
    assign mul_last = (step_lo & ({XLEN{1'b1}} >> steps)) == '0;
    assign prod     = {step_hi, step_lo} >> (CNT_W'(XLEN) - steps);
    assign mul_zero = (a == '0) || (b == '0);
`else
    assign mul_last = (cnt_q == CNT_W'(XLEN - 1));
    assign prod     = {step_hi, step_lo};
    assign mul_zero = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        wrk_d   = wrk_q;
        opd_d   = opd_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        case (state_q)
            IDLE: begin
                if (start && op == OP_MULTU) begin
                    if (mul_zero) begin
                        hi_d    = '0;
                        lo_d    = '0;
                        state_d = FIN;
                    end else begin
                        opd_d   = a;
                        wrk_d   = b;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = MUL;
                    end
                end else if (start && op == OP_DIVU) begin
                    if (b == '0) begin
                        hi_d    = a;
                        lo_d    = '1;
                        state_d = FIN;
                    end else begin
                        opd_d   = b;
                        wrk_d   = a;
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                acc_d = step_hi;
                wrk_d = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (mul_last) begin
                    hi_d    = prod[2*XLEN-1:XLEN];
                    lo_d    = prod[XLEN-1:0];
                    state_d = FIN;
                end
            end
            DIV: begin
                acc_d = step_hi;
                wrk_d = step_lo;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(XLEN - 1)) begin
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    state_d = FIN;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            wrk_q   <= '0;
            opd_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            wrk_q   <= wrk_d;
            opd_q   <= opd_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    assign busy  = (state_q != IDLE);
    assign done  = (state_q == FIN);
    assign stall = busy && start && is_muldiv_op(op);
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
Multi-cycle controller for the integer multiply/divide resource and its HI/LO register pair. It replaces single-cycle combinational A*B and A/B, A%B with an iterative shift-add multiplier and a restoring divider. The block stalls the main datapath while busy and exposes HI/LO for MFHI/MFLO. It sits beside the ALU; the ALU's op-11/12 results come from this block's hi/lo outputs.

Parameters:
XLEN, 32, operand width; HI/LO are each XLEN bits.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > XLEN.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request; sampled only in IDLE.
op  input  5  ALU operation code; 5'd14 = MULTU, 5'd13 = DIVU, 5'd12 = MFHI, 5'd11 = MFLO.
a  input  XLEN  operand A (multiplicand / dividend).
b  input  XLEN  operand B (multiplier / divisor).
busy  output  1  high whenever state != IDLE.
done  output  1  one-cycle pulse when HI/LO hold a new result.
stall  output  1  combinational: busy && start && op in {11,12,13,14}.
hi  output  XLEN  HI register (product high half / remainder).
lo  output  XLEN  LO register (product low half / quotient).

Behaviour:
- One clock domain (clk). rst is asynchronous and active-high.
- Reset values: state = IDLE; busy, done = 0; hi, lo = 0; counter and working registers = 0.
- States: IDLE, MUL, DIV, FIN.
- IDLE: on start with op 14, latch a and b, clear the accumulator, counter = 0, then go to MUL. On start with op 13 and b != 0, latch, clear the partial remainder, then go to DIV. All other ops, or start = 0, stay in IDLE.
- MUL: one shift-add step per cycle, unsigned. Step: if the multiplier LSB is 1, accumulator += multiplicand with a (XLEN+1)-bit carry; then shift {acc, mplier} right by 1. After XLEN steps (counter == XLEN-1), load {hi, lo} with the 2*XLEN product and go to FIN.
- DIV: restoring, unsigned, one quotient bit per cycle, MSB first. After XLEN steps, load lo with the quotient and hi with the remainder, then go to FIN.
- Divide by zero (op 13, b == 0): go directly to FIN. Load lo = all ones and hi = a. done follows one cycle later.
- FIN: done = 1 for exactly one cycle, then go to IDLE.
- Latency, with the accepting edge as t0: hi/lo update at edge t0+XLEN, and done is high during cycle XLEN+1. Divide by zero: hi/lo update at t0, and done is high in cycle 1.
- start while busy: ignored. No queueing; the requester holds the request under stall.
- Back-to-back: a start in the cycle after done (state is IDLE again) is accepted. Minimum spacing between accepts is XLEN+2 cycles.
- Operands are sampled only on the accepting edge; later changes on a/b have no effect.
- hi/lo change only at result load or reset; they are stable while busy.
- Reset mid-operation: IDLE immediately, partial result discarded, hi/lo = 0, done is not asserted.

Optional Feature:
MULDIV_EARLY_OUT_EN
- Defined: MULTU with a == 0 or b == 0 goes straight to FIN with hi = lo = 0, giving the same latency as divide by zero.
- Defined: MUL terminates once the remaining multiplier bits are all zero. The product is shifted into its final alignment on load; latency is 1 + index of the highest set bit of b.
- Undefined: fixed XLEN-cycle latency for every MULTU. Results are identical in both builds; only timing differs.

Decomposition:
- Package muldiv_pkg holds:
  - XLEN.
  - Op-code localparams OP_MFLO = 5'd11, OP_MFHI = 5'd12, OP_DIVU = 5'd13, OP_MULTU = 5'd14, shared with the ALU decoder.
  - The state enum {IDLE, MUL, DIV, FIN}.
- One sub-module, muldiv_step: a combinational single-iteration datapath (add-shift or subtract-restore selected by a mode bit). The FSM, counter and HI/LO registers stay in muldiv_sequencer.

Test Plan:
- MULTU a=12, b=4 → busy for 33 cycles; done pulse at cycle 33; hi=0, lo=48; stall high only while busy and start is held.
- MULTU a=b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001.
- DIVU a=13, b=4 → lo=3, hi=1; DIVU a=32'h80000000, b=1 → lo=32'h80000000, hi=0.
- DIVU a=7, b=0 → done high in cycle 1; lo=32'hFFFFFFFF, hi=7.
- Start MULTU 5*6. Pulse start with DIVU 9/3 at cycle 10 → DIVU ignored; result hi=0, lo=30. Then issue DIVU 9/3 in the cycle after done → accepted; lo=3, hi=0.
- Start DIVU 100/7, assert rst at cycle 15 → busy=0 and hi=lo=0 immediately; no done pulse. A subsequent MULTU 3*3 gives lo=9.
